seq_divider: RTL and testbench

- Parametrised multi-cycle restoring divider with start/done handshake, signed/unsigned mode and divide-by-zero detection.
- Next-generation replacement for the fixed 4-bit datapath/control divider pair: one self-contained block that the top-level controller or CPU execute stage drives with a single start pulse.
- Produces quotient and remainder after a fixed, width-dependent latency.

---
 rtl/seq_divider.sv | 165 ++++++++++++++++
 tb/tb_seq_divider.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring divider with a start/done handshake, a signed or
//   unsigned operand mode and divide-by-zero detection.
//
//   Handshake: a request is taken on any rising edge where start=1 while the
//   block is idle. Operands and mode are captured on that edge only and may
//   change afterwards. busy stays high from the next cycle until the result
//   is ready. done is a single-cycle pulse that marks quotient, remainder and
//   div_by_zero as valid. Those outputs then hold until the next done pulse.
//   A start that arrives while busy is ignored.
//
// Ports
//   clk          clock
//   rst          asynchronous, active-high reset
//   start        request, sampled only in IDLE
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   dividend     dividend (sampled with start)
//   divisor      divisor  (sampled with start)
//   busy         operation in progress (excludes the done cycle)
//   done         one-cycle result-valid pulse
//   quotient     quotient, held until next done
//   remainder    remainder, held until next done
//   div_by_zero  divisor was zero, held until next done
//   dbg_state    current FSM state, for observation only
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    // Working registers
    logic [WIDTH:0]   r_q;        // partial remainder, one extra bit for the trial subtract
    logic [WIDTH-1:0] qw_q;       // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] y_q;        // divisor magnitude
    logic [CNT_W-1:0] cnt_q;      // iterations left
    logic             neg_q_q;    // negate quotient in FIX
    logic             neg_r_q;    // negate remainder in FIX
    logic             zero_err_q; // divisor was zero

    // One restoring step
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        trial = {r_q[WIDTH-1:0], qw_q[WIDTH-1]};
        diff  = trial - {1'b0, y_q};
        fits  = (trial >= {1'b0, y_q});
    end

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    // A zero divisor skips the iterations entirely.
                    state_next = (divisor == '0) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // ---------------- Datapath and result registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q         <= '0;
            qw_q        <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            zero_err_q  <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        neg_q_q    <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r_q    <= signed_mode & dividend[WIDTH-1];
                        zero_err_q <= (divisor == '0);
                        r_q        <= '0;
                        cnt_q      <= CNT_W'(WIDTH);
                        y_q        <= (signed_mode && divisor[WIDTH-1]) ? -divisor : divisor;
                        // With a zero divisor the raw dividend is kept, since it
                        // becomes the reported remainder unchanged.
                        if (divisor == '0) begin
                            qw_q <= dividend;
                        end else if (signed_mode && dividend[WIDTH-1]) begin
                            qw_q <= -dividend;
                        end else begin
                            qw_q <= dividend;
                        end
                    end
                end
                S_RUN: begin
                    r_q   <= fits ? diff : trial;
                    qw_q  <= {qw_q[WIDTH-2:0], fits};
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                S_FIX: begin
                    done        <= 1'b1;
                    div_by_zero <= zero_err_q;
                    if (zero_err_q) begin
                        quotient  <= '1;
                        remainder <= qw_q;
                    end else begin
                        // The most-negative / -1 case yields magnitude 2^(WIDTH-1)
                        // with no negation, which is the wrapped result.
                        quotient  <= neg_q_q ? -qw_q : qw_q;
                        remainder <= neg_r_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic clk;
    logic rst;

    // 8-bit instance
    logic        start8, sm8, busy8, done8, dz8;
    logic [7:0]  a8, b8, q8, r8;
    logic [1:0]  st8;
    // 16-bit instance
    logic        start16, sm16, busy16, done16, dz16;
    logic [15:0] a16, b16, q16, r16;
    logic [1:0]  st16;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(8)) u_div8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .dividend(a8), .divisor(b8), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dz8), .dbg_state(st8)
    );

    seq_divider #(.WIDTH(16)) u_div16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .dividend(a16), .divisor(b16), .busy(busy16), .done(done16),
        .quotient(q16), .remainder(r16), .div_by_zero(dz16), .dbg_state(st16)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division with truncation toward zero;
    // zero divisor gives all-ones quotient and the raw dividend.
    function automatic void ref_div(input int w, input logic [15:0] a, input logic [15:0] b,
                                    input bit sm, output logic [15:0] q,
                                    output logic [15:0] r, output bit dz);
        longint sa, sb, mask, lq, lr;
        mask = (longint'(1) << w) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (sb == 0) begin
            q  = 16'(mask);
            r  = 16'(sa);
            dz = 1'b1;
            return;
        end
        if (sm) begin
            if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
            if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        end
        lq = sa / sb;
        lr = sa % sb;
        q  = 16'(lq & mask);
        r  = 16'(lr & mask);
        dz = 1'b0;
    endfunction

    // ---------------- drivers / observers ----------------
    task automatic drive(input int w, input bit st, input bit sm, input logic [15:0] a,
                         input logic [15:0] b);
        if (w == 8) begin
            start8 = st; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start16 = st; sm16 = sm; a16 = a; b16 = b;
        end
    endtask

    function automatic bit obs_done(input int w);
        return (w == 8) ? done8 : done16;
    endfunction
    function automatic bit obs_busy(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction
    function automatic bit obs_dz(input int w);
        return (w == 8) ? dz8 : dz16;
    endfunction
    function automatic logic [15:0] obs_q(input int w);
        return (w == 8) ? {8'h00, q8} : q16;
    endfunction
    function automatic logic [15:0] obs_r(input int w);
        return (w == 8) ? {8'h00, r8} : r16;
    endfunction

    // One full operation: start pulse, bounded wait for done, result and
    // timing checks, then confirm done drops and results hold.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input bit sm, input string tag);
        logic [15:0] eq, er, mask, rnd_a, rnd_b;
        bit          edz, seen;
        int          k, busy_n, exp_lat;
        mask = (w == 8) ? 16'h00FF : 16'hFFFF;
        ref_div(w, a & mask, b & mask, sm, eq, er, edz);
        exp_lat = ((b & mask) == 16'h0) ? 1 : w + 1;
        @(negedge clk);
        drive(w, 1'b1, sm, a & mask, b & mask);
        k = 0; busy_n = 0; seen = 1'b0;
        while (!seen && k < 3 * w + 10) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                rnd_a = 16'($urandom);
                rnd_b = 16'($urandom);
                drive(w, 1'b0, ~sm, rnd_a & mask, rnd_b & mask);
            end
            if (obs_done(w)) seen = 1'b1;
            else if (obs_busy(w)) busy_n++;
        end
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(k - 1), 64'(exp_lat));
        check({tag, " busy_cycles"}, 64'(busy_n), 64'(exp_lat));
        check({tag, " busy_at_done"}, 64'(obs_busy(w)), 64'd0);
        check({tag, " quotient"}, 64'(obs_q(w)), 64'(eq));
        check({tag, " remainder"}, 64'(obs_r(w)), 64'(er));
        check({tag, " div_by_zero"}, 64'(obs_dz(w)), 64'(edz));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(obs_done(w)), 64'd0);
        check({tag, " quotient_hold"}, 64'(obs_q(w)), 64'(eq));
    endtask

    // ---------------- stimulus ----------------
    logic [7:0]  ah[0:39];
    logic [7:0]  bh[0:39];

    initial begin
        logic [15:0] ra, rb, eq, er;
        bit          rsm, edz;
        int          last_done, n_done;

        // reset
        rst = 1'b1;
        drive(8, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(16, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        check("reset busy8", 64'(busy8), 64'd0);
        check("reset done8", 64'(done8), 64'd0);
        check("reset q8", 64'(q8), 64'd0);
        check("reset r8", 64'(r8), 64'd0);
        check("reset dz8", 64'(dz8), 64'd0);
        check("reset q16", 64'(q16), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // directed cases
        run_op(8, 16'd100, 16'd7, 1'b0, "u 100/7");
        run_op(8, 16'h9C, 16'd7, 1'b1, "s -100/7");
        run_op(8, 16'd100, 16'hF9, 1'b1, "s 100/-7");
        run_op(8, 16'd55, 16'd0, 1'b0, "u 55/0");
        run_op(8, 16'h9C, 16'd0, 1'b1, "s -100/0");
        run_op(8, 16'h80, 16'hFF, 1'b1, "s -128/-1");
        run_op(8, 16'd5, 16'd9, 1'b0, "u 5/9");
        run_op(8, 16'hFF, 16'h01, 1'b0, "u 255/1");
        run_op(16, 16'h8000, 16'hFFFF, 1'b1, "s16 min/-1");
        run_op(16, 16'd1234, 16'd0, 1'b1, "s16 x/0");

        // start held high: only requests seen in IDLE run, back to back
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0;
        last_done = -1; n_done = 0;
        for (int k = 0; k < 34; k++) begin
            if (k > 0 && done8) begin
                if (last_done >= 0) check("held spacing", 64'(k - last_done), 64'd10);
                if (k >= 10) begin
                    ref_div(8, {8'h00, ah[k-10]}, {8'h00, bh[k-10]}, 1'b0, eq, er, edz);
                    check("held quotient", 64'(q8), 64'(eq[7:0]));
                    check("held remainder", 64'(r8), 64'(er[7:0]));
                end
                last_done = k;
                n_done++;
            end
            ah[k] = 8'($urandom);
            bh[k] = 8'($urandom_range(1, 255));
            a8 = ah[k];
            b8 = bh[k];
            @(negedge clk);
        end
        check("held done_count", 64'(n_done), 64'd3);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // reset in the middle of an operation
        run_op(8, 16'd200, 16'd3, 1'b0, "pre-reset 200/3");
        @(negedge clk);
        drive(8, 1'b1, 1'b0, 16'd90, 16'd4);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset busy", 64'(busy8), 64'd0);
        check("midreset done", 64'(done8), 64'd0);
        check("midreset q", 64'(q8), 64'd0);
        check("midreset r", 64'(r8), 64'd0);
        check("midreset dz", 64'(dz8), 64'd0);
        #1;
        rst = 1'b0;
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) n_done++;
        end
        check("midreset no_done", 64'(n_done), 64'd0);
        run_op(8, 16'd90, 16'd4, 1'b0, "post-reset 90/4");

        // random sweeps
        for (int i = 0; i < 1500; i++) begin
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom);
            rsm = 1'($urandom_range(0, 1));
            run_op(8, ra, rb, rsm, "rand8");
        end
        for (int i = 0; i < 600; i++) begin
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 3) == 0) rb = rb & 16'h000F;
            rsm = 1'($urandom_range(0, 1));
            run_op(16, ra, rb, rsm, "rand16");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
